instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Fetches 16-bit instructions over the CPU's 8-bit byte-wide memory port.
//   Each instruction is two bytes, big-endian: the high byte is at PC and the low byte at PC+1.
//   It reads both bytes, assembles the instruction word and presents it to the decoder
//   with a valid/ready handshake. It owns the program counter and applies branch redirects.
// PARAMETERS
//   ADDR_W    8   width of PC and memory address; all address arithmetic is modulo 2^ADDR_W
//   RESET_PC  0   PC value loaded on reset
// PORTS
//   clk            in   1       system clock, rising edge
//   rst_n          in   1       asynchronous active-low reset
//   mem_req        out  1       byte read request; held high until mem_ack
//   mem_addr       out  ADDR_W  byte address of the current request
//   mem_ack        in   1       mem_rdata valid this cycle; only honoured while mem_req=1
//   mem_rdata      in   8       read data byte
//   instr          out  16      assembled instruction {hi,lo}
//   instr_valid    out  1       instr holds a complete instruction
//   instr_ready    in   1       decoder accepts instr this cycle
//   branch_en      in   1       redirect request; 1-cycle pulse
//   branch_target  in   ADDR_W  new PC when branch_en=1
//   pc             out  ADDR_W  address of the instruction being fetched or held
// BEHAVIOUR
//   State machine: IDLE -> FETCH_HI -> FETCH_LO -> HOLD -> FETCH_HI ...
//   Reset (async, rst_n=0):
//     - state=IDLE, pc=RESET_PC, instr=16'h0000.
//     - instr_valid=0, mem_req=0, hi byte register=0.
//   IDLE: mem_req=0. Moves to FETCH_HI unconditionally on the first clk edge after reset release.
//   FETCH_HI:
//     - mem_req=1, mem_addr=pc.
//     - On mem_ack: hi<=mem_rdata, then go to FETCH_LO. Otherwise stay.
//   FETCH_LO:
//     - mem_req=1, mem_addr=pc+1 (wraps from 2^ADDR_W-1 to 0).
//     - On mem_ack: instr<={hi,mem_rdata}, instr_valid<=1, then go to HOLD.
//   HOLD:
//     - mem_req=0; instr and instr_valid are stable.
//     - On instr_ready: pc<=pc+2 (mod 2^ADDR_W), instr_valid<=0, then go to FETCH_HI.
//   mem_req and mem_addr are decoded from state and pc only; they do not combinationally depend on mem_ack.
//   Latency: with zero-wait memory (mem_ack in the same cycle as mem_req), instr_valid rises
//     2 cycles after entering FETCH_HI. Best-case throughput is one instruction per 3 cycles.
//   instr_ready while instr_valid=0 is ignored.
//   Branch (branch_en=1, any state except IDLE) has priority over all other events:
//     - pc<=branch_target, instr_valid<=0, state<=FETCH_HI.
//     - A mem_ack in the same cycle is discarded.
//     - An instr_ready in the same cycle does not increment pc.
//   branch_en while in IDLE: pc<=branch_target, and the state still moves to FETCH_HI.
//   Odd PC and odd branch targets are legal; no alignment checks are made.
//   rst_n assertion mid-fetch aborts immediately; the partial hi byte is not retained.
//   Any mem_rdata is accepted; there is no error path.
// TESTING
//   1. Reset with RESET_PC=0; memory holds [0]=8'hA5, [1]=8'h3C; zero-wait ack; instr_ready=1
//      -> mem_req rises 1 cycle after reset release; instr=16'hA53C with instr_valid=1; then pc=2.
//   2. 2-cycle wait states on each byte; instr_ready=0 for 5 cycles
//      -> mem_req held through the waits; instr_valid stays 1 and instr stays stable; pc unchanged until ready.
//   3. pc=8'hFE; memory [FE]=8'h12, [FF]=8'h34, [00]=8'h56
//      -> instr=16'h1234 and the next pc=8'h00; with pc=8'hFF, mem_addr sequence is FF then 00.
//   4. branch_en with target 8'h40 asserted in FETCH_LO coincident with mem_ack
//      -> ack is discarded; next mem_addr=8'h40 in FETCH_HI; no instr_valid pulse for the old fetch.
//   5. branch_en and instr_ready in the same HOLD cycle, target 8'h10
//      -> pc=8'h10 (not pc+2); instr_valid=0 on the next cycle.
//   6. rst_n pulsed low during FETCH_LO
//      -> mem_req=0 and instr_valid=0 immediately; pc=RESET_PC; fetch restarts with a fresh hi byte.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: byte-wide memory read port, decoder handshake,
// branch redirect and the program counter view.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 8
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic [15:0]       instr;
  logic              instr_valid;
  logic              instr_ready;
  logic              branch_en;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] pc;

  modport master (
    output mem_req, mem_addr, instr, instr_valid, pc,
    input  mem_ack, mem_rdata, instr_ready, branch_en, branch_target
  );

  modport slave (
    input  mem_req, mem_addr, instr, instr_valid, pc,
    output mem_ack, mem_rdata, instr_ready, branch_en, branch_target
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads a big-endian 16-bit instruction as two bytes
// (hi at pc, lo at pc+1), holds it for the decoder and owns the PC.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_HI = 2'd1,
    FETCH_LO = 2'd2,
    HOLD     = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        hi_q, hi_d;
  logic [15:0]       instr_q, instr_d;
  logic              valid_q, valid_d;

  // State and datapath registers; reset aborts any fetch in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      hi_q    <= 8'h00;
      instr_q <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hi_q    <= hi_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic; a branch outside IDLE overrides every other event.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hi_d    = hi_q;
    instr_d = instr_q;
    valid_d = valid_q;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH_HI;
        if (bus.branch_en) pc_d = bus.branch_target;
      end
      FETCH_HI: begin
        if (bus.mem_ack) begin
          hi_d    = bus.mem_rdata;
          state_d = FETCH_LO;
        end
      end
      FETCH_LO: begin
        if (bus.mem_ack) begin
          instr_d = {hi_q, bus.mem_rdata};
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.instr_ready && valid_q) begin
          pc_d    = pc_q + ADDR_W'(2);
          valid_d = 1'b0;
          state_d = FETCH_HI;
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect discards any coincident ack and suppresses the pc+2 step.
    if (bus.branch_en && state_q != IDLE) begin
      pc_d    = bus.branch_target;
      hi_d    = hi_q;
      instr_d = instr_q;
      valid_d = 1'b0;
      state_d = FETCH_HI;
    end
  end

  // Memory request decoded from state and pc only (never from mem_ack).
  always_comb begin
    bus.mem_req  = (state_q == FETCH_HI) || (state_q == FETCH_LO);
    bus.mem_addr = (state_q == FETCH_LO) ? pc_q + ADDR_W'(1) : pc_q;
  end

  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a byte memory model, configurable
// wait states and a scoreboard of expected instruction words.
module tb_instr_fetch_unit;

  logic clk;
  logic rst_n;

  instr_fetch_unit_if #(.ADDR_W(8)) bus ();

  instr_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack after n_wait cycles of a held request.
  logic [7:0] mem [256];
  int         n_wait;
  int         wait_cnt;

  assign bus.mem_ack   = bus.mem_req && (wait_cnt >= n_wait);
  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          wait_cnt <= 0;
    else if (!bus.mem_req || bus.mem_ack) wait_cnt <= 0;
    else                                 wait_cnt <= wait_cnt + 1;
  end

  logic [15:0] sb_q [$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for instr_valid, then pop and compare the instruction.
  task automatic wait_valid(input string tag, input int max_cyc);
    logic [15:0] exp;
    int n;
    n = 0;
    while (bus.instr_valid !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, {31'd0, bus.instr_valid}, 32'd1);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
    chk({tag, "_instr"}, {16'd0, bus.instr}, {16'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
    rst_n             = 1'b0;
    n_wait            = 0;
    bus.instr_ready   = 1'b1;
    bus.branch_en     = 1'b0;
    bus.branch_target = 8'h00;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_req",   {31'd0, bus.mem_req},     32'd0);
    chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_instr", {16'd0, bus.instr},       32'h0000);
    chk("rst_pc",    {24'd0, bus.pc},          32'h00);

    // Test 1: zero-wait fetch from 0
    mem[0] = 8'hA5; mem[1] = 8'h3C;
    sb_q.push_back({mem[0], mem[1]});
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_req",   {31'd0, bus.mem_req},  32'd1);
    chk("t1_addr0", {24'd0, bus.mem_addr}, 32'h00);
    @(negedge clk);
    chk("t1_addr1", {24'd0, bus.mem_addr}, 32'h01);
    @(negedge clk);
    wait_valid("t1", 0);
    chk("t1_pc_hold", {24'd0, bus.pc}, 32'h00);
    @(negedge clk);
    chk("t1_pc2",    {24'd0, bus.pc},          32'h02);
    chk("t1_vld0",   {31'd0, bus.instr_valid}, 32'd0);

    // Test 2: two wait states per byte, decoder stalls 5 cycles
    mem[2] = 8'hBE; mem[3] = 8'hEF;
    sb_q.push_back({mem[2], mem[3]});
    n_wait = 2;
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_req_hi",  {31'd0, bus.mem_req},  32'd1);
      chk("t2_addr_hi", {24'd0, bus.mem_addr}, 32'h02);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      chk("t2_req_lo",  {31'd0, bus.mem_req},  32'd1);
      chk("t2_addr_lo", {24'd0, bus.mem_addr}, 32'h03);
      @(negedge clk);
    end
    wait_valid("t2", 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_hold_vld",   {31'd0, bus.instr_valid}, 32'd1);
      chk("t2_hold_instr", {16'd0, bus.instr},       32'hBEEF);
      chk("t2_hold_pc",    {24'd0, bus.pc},          32'h02);
      chk("t2_hold_req",   {31'd0, bus.mem_req},     32'd0);
    end
    n_wait = 0;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    chk("t2_pc4",  {24'd0, bus.pc},          32'h04);
    chk("t2_vld0", {31'd0, bus.instr_valid}, 32'd0);

    // Test 3: wrap at top of address space
    mem[8'hFE] = 8'h12; mem[8'hFF] = 8'h34; mem[8'h00] = 8'h56;
    bus.branch_en = 1'b1; bus.branch_target = 8'hFE;
    @(negedge clk);
    bus.branch_en = 1'b0;
    sb_q.push_back({mem[8'hFE], mem[8'hFF]});
    chk("t3_pc_fe",   {24'd0, bus.pc},       32'hFE);
    chk("t3_addr_fe", {24'd0, bus.mem_addr}, 32'hFE);
    @(negedge clk);
    chk("t3_addr_ff", {24'd0, bus.mem_addr}, 32'hFF);
    @(negedge clk);
    wait_valid("t3a", 0);
    @(negedge clk);
    chk("t3_pc_wrap", {24'd0, bus.pc},       32'h00);
    chk("t3_addr_00", {24'd0, bus.mem_addr}, 32'h00);
    bus.branch_en = 1'b1; bus.branch_target = 8'hFF;
    @(negedge clk);
    bus.branch_en = 1'b0;
    sb_q.push_back({mem[8'hFF], mem[8'h00]});
    chk("t3b_addr_ff", {24'd0, bus.mem_addr}, 32'hFF);
    @(negedge clk);
    chk("t3b_addr_00", {24'd0, bus.mem_addr}, 32'h00);
    @(negedge clk);
    wait_valid("t3b", 0);
    bus.instr_ready = 1'b0;
    @(negedge clk);
    // ready was dropped before this edge, so pc holds at FF
    chk("t3b_pc_hold", {24'd0, bus.pc}, 32'hFF);
    bus.instr_ready = 1'b1;
    @(negedge clk);
    chk("t3b_pc_01", {24'd0, bus.pc}, 32'h01);
    bus.instr_ready = 1'b0;

    // Test 4: branch coincident with the lo-byte ack
    mem[8'h40] = 8'h9A; mem[8'h41] = 8'hBC;
    @(negedge clk);
    chk("t4_addr_lo", {24'd0, bus.mem_addr}, 32'h02);
    bus.branch_en = 1'b1; bus.branch_target = 8'h40;
    @(negedge clk);
    bus.branch_en = 1'b0;
    sb_q.push_back({mem[8'h40], mem[8'h41]});
    chk("t4_vld0",    {31'd0, bus.instr_valid}, 32'd0);
    chk("t4_addr_40", {24'd0, bus.mem_addr},    32'h40);
    chk("t4_pc_40",   {24'd0, bus.pc},          32'h40);
    @(negedge clk);
    chk("t4_vld0b",   {31'd0, bus.instr_valid}, 32'd0);
    chk("t4_addr_41", {24'd0, bus.mem_addr},    32'h41);
    @(negedge clk);
    wait_valid("t4", 0);

    // Test 5: branch and ready together in HOLD
    bus.instr_ready = 1'b1;
    bus.branch_en = 1'b1; bus.branch_target = 8'h10;
    @(negedge clk);
    bus.branch_en = 1'b0;
    bus.instr_ready = 1'b0;
    chk("t5_pc_10",   {24'd0, bus.pc},          32'h10);
    chk("t5_vld0",    {31'd0, bus.instr_valid}, 32'd0);
    chk("t5_addr_10", {24'd0, bus.mem_addr},    32'h10);

    // Test 6: asynchronous reset during FETCH_LO
    @(negedge clk);
    chk("t6_addr_11", {24'd0, bus.mem_addr}, 32'h11);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req0", {31'd0, bus.mem_req},     32'd0);
    chk("t6_vld0", {31'd0, bus.instr_valid}, 32'd0);
    chk("t6_pc0",  {24'd0, bus.pc},          32'h00);
    bus.instr_ready = 1'b1;
    sb_q.push_back({mem[8'h00], mem[8'h01]});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_req1",    {31'd0, bus.mem_req},  32'd1);
    chk("t6_addr_hi", {24'd0, bus.mem_addr}, 32'h00);
    @(negedge clk);
    chk("t6_addr_lo", {24'd0, bus.mem_addr}, 32'h01);
    @(negedge clk);
    wait_valid("t6", 0);

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
